// File: rtl/uart_slot_seq.sv
// Sequencer for a memory-mapped UART slot: writes the initial baud divisor, then round-robins
// status polling, divisor updates, tx byte writes and rx FIFO pops.
module uart_slot_seq #(
  parameter logic [13:0] DVSR_INIT = 14'd53
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [13:0] cfg_dvsr,
  input  logic        cfg_wr,
  output logic        init_done,
  output logic        cs,
  output logic        read,
  output logic        write,
  output logic [4:0]  addr,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_data
);

  typedef enum logic [2:0] {StInit, StPoll, StDecide, StCfg, StTxWr, StRxPop} state_e;

  state_e      state_q, state_d;
  logic [7:0]  tx_hold_q, tx_hold_d;
  logic        tx_held_q, tx_held_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        init_done_q, init_done_d;
  logic        cfg_pend_q, cfg_pend_d;
  logic [13:0] cfg_dvsr_q, cfg_dvsr_d;
  logic        last_rx_q, last_rx_d;  // 1 = rx served last, 0 = tx served last
  logic [9:0]  status_q, status_d;

  logic        rx_elig, tx_elig;
  logic        cs_c, read_c, write_c;
  logic [4:0]  addr_c;
  logic [31:0] wr_data_c;
  logic        unused_rd;

  assign unused_rd = ^rd_data[31:10];

  // Decisions use only the latched status, never the live rd_data.
  assign rx_elig = !status_q[8] && !rx_valid_q;
  assign tx_elig = tx_held_q && !status_q[9];

  always_comb begin
    state_d     = state_q;
    tx_hold_d   = tx_hold_q;
    tx_held_d   = tx_held_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    init_done_d = init_done_q;
    cfg_pend_d  = cfg_pend_q;
    cfg_dvsr_d  = cfg_dvsr_q;
    last_rx_d   = last_rx_q;
    status_d    = status_q;

    case (state_q)
      StInit: begin
        init_done_d = 1'b1;
        state_d     = StPoll;
      end
      StPoll: begin
        status_d = rd_data[9:0];
        state_d  = StDecide;
      end
      StDecide: begin
        if (cfg_pend_q) begin
          state_d = StCfg;
        end else if (rx_elig && (!tx_elig || !last_rx_q)) begin
          rx_data_d  = status_q[7:0];
          rx_valid_d = 1'b1;
          state_d    = StRxPop;
        end else if (tx_elig) begin
          state_d = StTxWr;
        end else begin
          state_d = StPoll;
        end
      end
      StCfg: begin
        cfg_pend_d = 1'b0;
        state_d    = StPoll;
      end
      StTxWr: begin
        tx_held_d = 1'b0;
        last_rx_d = 1'b0;
        state_d   = StPoll;
      end
      StRxPop: begin
        last_rx_d = 1'b1;
        state_d   = StPoll;
      end
      default: state_d = StInit;
    endcase

    if (tx_valid && !tx_held_q) begin
      tx_held_d = 1'b1;
      tx_hold_d = tx_data;
    end
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    // A new request in the CFG cycle stays pending for a second write.
    if (cfg_wr) begin
      cfg_pend_d = 1'b1;
      cfg_dvsr_d = cfg_dvsr;
    end
  end

  always_comb begin
    cs_c      = 1'b0;
    read_c    = 1'b0;
    write_c   = 1'b0;
    addr_c    = 5'd0;
    wr_data_c = 32'd0;
    case (state_q)
      StInit: begin
        cs_c      = 1'b1;
        write_c   = 1'b1;
        addr_c    = 5'd1;
        wr_data_c = {18'b0, DVSR_INIT};
      end
      StPoll: begin
        cs_c   = 1'b1;
        read_c = 1'b1;
      end
      StCfg: begin
        cs_c      = 1'b1;
        write_c   = 1'b1;
        addr_c    = 5'd1;
        wr_data_c = {18'b0, cfg_dvsr_q};
      end
      StTxWr: begin
        cs_c      = 1'b1;
        write_c   = 1'b1;
        addr_c    = 5'd2;
        wr_data_c = {24'b0, tx_hold_q};
      end
      StRxPop: begin
        cs_c    = 1'b1;
        write_c = 1'b1;
        addr_c  = 5'd3;
      end
      default: ;
    endcase
  end

  // State sits at StInit during reset; gate the strobes so the slot sees nothing until release.
  assign cs        = cs_c & reset_n;
  assign read      = read_c & reset_n;
  assign write     = write_c & reset_n;
  assign addr      = addr_c & {5{reset_n}};
  assign wr_data   = wr_data_c & {32{reset_n}};
  assign tx_ready  = !tx_held_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign init_done = init_done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StInit;
      tx_hold_q   <= 8'd0;
      tx_held_q   <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
      cfg_pend_q  <= 1'b0;
      cfg_dvsr_q  <= 14'd0;
      last_rx_q   <= 1'b0;
      status_q    <= 10'h100;
    end else begin
      state_q     <= state_d;
      tx_hold_q   <= tx_hold_d;
      tx_held_q   <= tx_held_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      init_done_q <= init_done_d;
      cfg_pend_q  <= cfg_pend_d;
      cfg_dvsr_q  <= cfg_dvsr_d;
      last_rx_q   <= last_rx_d;
      status_q    <= status_d;
    end
  end

endmodule
